gpio_port_pcint: RTL

- Parametrised successor to the fixed 8-bit AVR port blocks: one generic GPIO port of P_WIDTH pins, mapped into the 6-bit I/O space.
- Contains PINx/DDRx/PORTx, a 2-flop input synchroniser and a per-pin alternate-function override mux with vector inputs.
- Adds a local pin-change interrupt unit (PCMSK mask, PCIF flag, irq output).
- One instance per port (B/C/D/E); the peripheral glue drives the override vectors.

---
 rtl/gpio_port_pcint.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gpio_port_pcint.sv
// Generic GPIO port (PINx/DDRx/PORTx) with input synchroniser, alternate-function override mux
// and local pin-change interrupt. Optional PINx write-to-toggle enabled by GPIO_PIN_TOGGLE_EN.
module gpio_port_pcint #(
    parameter int unsigned P_WIDTH    = 8,
    parameter logic [5:0]  PINX_ADDR  = 6'h03,
    parameter logic [5:0]  DDRX_ADDR  = 6'h04,
    parameter logic [5:0]  PORTX_ADDR = 6'h05,
    parameter logic [5:0]  PCMSK_ADDR = 6'h1A,
    parameter logic [5:0]  PCIF_ADDR  = 6'h1B
) (
    input  logic               cp2,
    input  logic               ireset,
    input  logic [5:0]         IO_Addr,
    input  logic               iore,
    input  logic               iowe,
    input  logic [7:0]         dbus_in,
    output logic [7:0]         dbus_out,
    output logic               out_en,
    input  logic [P_WIDTH-1:0] pin_i,
    input  logic               PUD,
    input  logic               SLEEP,
    input  logic               PCIE,
    input  logic               irq_ack,
    input  logic [P_WIDTH-1:0] puoe,
    input  logic [P_WIDTH-1:0] puov,
    input  logic [P_WIDTH-1:0] ddoe,
    input  logic [P_WIDTH-1:0] ddov,
    input  logic [P_WIDTH-1:0] pvoe,
    input  logic [P_WIDTH-1:0] pvov,
    input  logic [P_WIDTH-1:0] dieoe,
    input  logic [P_WIDTH-1:0] dieov,
    output logic [P_WIDTH-1:0] pu_n,
    output logic [P_WIDTH-1:0] dd,
    output wire  [P_WIDTH-1:0] pv,
    output logic [P_WIDTH-1:0] die,
    output logic [P_WIDTH-1:0] din_o,
    output logic               irq
);

    logic [P_WIDTH-1:0] port_q, port_d;
    logic [P_WIDTH-1:0] ddr_q, ddr_d;
    logic [P_WIDTH-1:0] pcmsk_q, pcmsk_d;
    logic [P_WIDTH-1:0] s1_q, s1_d;
    logic [P_WIDTH-1:0] s2_q, s2_d;
    logic [P_WIDTH-1:0] prev_q, prev_d;
    logic               pcif_q, pcif_d;

    logic [P_WIDTH-1:0] wdata;
    logic [P_WIDTH-1:0] pv_val;
    logic [P_WIDTH-1:0] chg;
    logic               sel_pin, sel_ddr, sel_port, sel_pcmsk, sel_pcif;
    logic               pc_set, pc_clr;

    assign wdata     = dbus_in[P_WIDTH-1:0];
    assign sel_pin   = (IO_Addr == PINX_ADDR);
    assign sel_ddr   = (IO_Addr == DDRX_ADDR);
    assign sel_port  = (IO_Addr == PORTX_ADDR);
    assign sel_pcmsk = (IO_Addr == PCMSK_ADDR);
    assign sel_pcif  = (IO_Addr == PCIF_ADDR);

    // Alternate-function override mux
    always_comb begin
        pu_n   = ~((puoe & puov) | (~puoe & port_q & ~ddr_q & ~{P_WIDTH{PUD}}));
        dd     = (ddoe & ddov) | (~ddoe & ddr_q);
        pv_val = (pvoe & pvov) | (~pvoe & port_q);
        die    = (dieoe & ~dieov) | (~dieoe & {P_WIDTH{SLEEP}});
        din_o  = s2_q;
        irq    = pcif_q & PCIE;
    end

    for (genvar i = 0; i < int'(P_WIDTH); i++) begin : g_pv
        assign pv[i] = dd[i] ? pv_val[i] : 1'bz;
    end

    // Register writes, synchroniser and pin-change flag
    always_comb begin
        port_d  = port_q;
        ddr_d   = ddr_q;
        pcmsk_d = pcmsk_q;
        if (iowe) begin
            if (sel_ddr)   ddr_d   = wdata;
            if (sel_pcmsk) pcmsk_d = wdata;
`ifdef GPIO_PIN_TOGGLE_EN
            if (sel_pin)   port_d  = port_q ^ wdata;
`endif
            // A direct PORTx write takes priority over a toggle
            if (sel_port)  port_d  = wdata;
        end

        s1_d   = pin_i & ~die;
        s2_d   = s1_q;
        prev_d = s2_q;

        // Only edges of s2 count, so retargeting PCMSK never flags by itself
        chg    = (s2_q ^ prev_q) & pcmsk_q;
        pc_set = |chg;
        pc_clr = irq_ack | (iowe & sel_pcif & dbus_in[0]);
        pcif_d = pcif_q;
        if (pc_clr) pcif_d = 1'b0;
        if (pc_set) pcif_d = 1'b1;
    end

    always_ff @(posedge cp2) begin
        if (ireset) begin
            port_q  <= '0;
            ddr_q   <= '0;
            pcmsk_q <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            pcif_q  <= 1'b0;
        end else begin
            port_q  <= port_d;
            ddr_q   <= ddr_d;
            pcmsk_q <= pcmsk_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= prev_d;
            pcif_q  <= pcif_d;
        end
    end

    // Combinational read mux
    always_comb begin
        dbus_out = 8'h00;
        out_en   = 1'b0;
        if (iore) begin
            if (sel_pin) begin
                out_en   = 1'b1;
                dbus_out = 8'(s2_q);
            end else if (sel_ddr) begin
                out_en   = 1'b1;
                dbus_out = 8'(ddr_q);
            end else if (sel_port) begin
                out_en   = 1'b1;
                dbus_out = 8'(port_q);
            end else if (sel_pcmsk) begin
                out_en   = 1'b1;
                dbus_out = 8'(pcmsk_q);
            end else if (sel_pcif) begin
                out_en   = 1'b1;
                dbus_out = 8'(pcif_q);
            end
        end
    end

endmodule
